// File: rtl/tp_gen_pkg.sv
// rtl/tp_gen_pkg.sv - shared encodings and PRBS31 constants for the test pattern generator
package tp_gen_pkg;

  typedef enum logic [2:0] {
    TP_IDLE     = 3'd0,
    TP_STATIC_0 = 3'd1,
    TP_STATIC_1 = 3'd2,
    TP_CNT      = 3'd3,
    TP_RANDOM   = 3'd4
  } test_pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } tp_state_e;

  // x^31 + x^28 + 1 taps, as bit positions of a 31-bit shift register
  localparam int          PRBS31_TAP_HI   = 30;
  localparam int          PRBS31_TAP_LO   = 27;
  localparam logic [30:0] PRBS31_ALL_ONES = 31'h7FFF_FFFF;

  function automatic logic prbs31_fb(input logic [30:0] s);
    return s[PRBS31_TAP_HI] ^ s[PRBS31_TAP_LO];
  endfunction

  // An all-zero state would lock the LFSR, so zero seeds become all-ones
  function automatic logic [30:0] prbs31_fix_seed(input logic [30:0] seed);
    return (seed == 31'd0) ? PRBS31_ALL_ONES : seed;
  endfunction

endpackage

// File: rtl/tp_gen_prbs31_step.sv
// rtl/tp_gen_prbs31_step.sv - combinational N-step PRBS31 advance
// o_bits[0] is the earliest serial bit; o_state is the register after N shifts.
module prbs31_step
  import tp_gen_pkg::*;
#(
  parameter int N = 96
) (
  input  logic [30:0]  i_state,
  output logic [30:0]  o_state,
  output logic [N-1:0] o_bits
);

  logic [30:0] w_s;

  always_comb begin
    w_s    = i_state;
    o_bits = '0;
    for (int k = 0; k < N; k++) begin
      o_bits[k] = prbs31_fb(w_s);
      w_s       = {w_s[29:0], o_bits[k]};
    end
    o_state = w_s;
  end

endmodule

// File: rtl/tp_gen.sv
// rtl/tp_gen.sv - test pattern generator top: config latch, run FSM, registered beat output
// Pattern state always describes the beat currently presented (or next to be presented).
module tp_gen
  import tp_gen_pkg::*;
#(
  parameter int NUM_LANES = 16,
  parameter int DATA_W    = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_load,
  input  logic [2:0]                  cfg_mode,
  input  logic [30:0]                 cfg_seed,
  input  logic [15:0]                 cfg_num_beats,
  input  logic                        en,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic                        done
);

  localparam int W = NUM_LANES * DATA_W;

  tp_state_e       r_state;
  tp_state_e       w_state_next;
  test_pattern_e   r_mode;
  logic [15:0]     r_num_beats;
  logic [15:0]     r_beat_cnt;
  logic [DATA_W-1:0] r_base;
  logic [30:0]     r_lfsr;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;

  logic              w_accept;
  logic              w_last;
  logic [DATA_W-1:0] w_base_next;
  logic [30:0]       w_lfsr_adv;
  logic [30:0]       w_unused_lfsr;
  logic [W-1:0]      w_bits_cur;
  logic [W-1:0]      w_bits_next;
  logic [W-1:0]      w_pat_cur;
  logic [W-1:0]      w_pat_next;

  // Second stage yields the following beat's bits so an accepted beat can be replaced in one edge
  prbs31_step #(.N(W)) u_step_cur (
    .i_state (r_lfsr),
    .o_state (w_lfsr_adv),
    .o_bits  (w_bits_cur)
  );

  prbs31_step #(.N(W)) u_step_next (
    .i_state (w_lfsr_adv),
    .o_state (w_unused_lfsr),
    .o_bits  (w_bits_next)
  );

  function automatic logic [W-1:0] f_pattern(input test_pattern_e mode,
                                             input logic [DATA_W-1:0] base,
                                             input logic [W-1:0] bits);
    logic [W-1:0] v;
    v = '0;
    case (mode)
      TP_STATIC_1: v = '1;
      TP_CNT: begin
        for (int i = 0; i < NUM_LANES; i++) begin
          v[i*DATA_W +: DATA_W] = base + DATA_W'(i);
        end
      end
      TP_RANDOM: v = bits;
      default:   v = '0;
    endcase
    return v;
  endfunction

  assign w_accept    = r_out_valid & out_ready;
  assign w_last      = w_accept && (r_num_beats != 16'd0) && ((r_beat_cnt + 16'd1) == r_num_beats);
  assign w_base_next = r_base + DATA_W'(NUM_LANES);
  assign w_pat_cur   = f_pattern(r_mode, r_base, w_bits_cur);
  assign w_pat_next  = f_pattern(r_mode, w_base_next, w_bits_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Priority: cfg_load, then completion, then en falling
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   w_state_next = ST_IDLE;
      ST_ARMED:  if (en && (r_mode != TP_IDLE)) w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_last)   w_state_next = ST_FINISH;
        else if (!en) w_state_next = ST_ARMED;
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (cfg_load) w_state_next = ST_ARMED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= TP_IDLE;
      r_num_beats <= '0;
      r_beat_cnt  <= '0;
      r_base      <= '0;
      r_lfsr      <= PRBS31_ALL_ONES;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (cfg_load) begin
      r_mode      <= (cfg_mode > 3'd4) ? TP_IDLE : test_pattern_e'(cfg_mode);
      r_num_beats <= cfg_num_beats;
      r_beat_cnt  <= '0;
      r_base      <= '0;
      r_lfsr      <= prbs31_fix_seed(cfg_seed);
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_accept) begin
        r_base     <= w_base_next;
        r_lfsr     <= w_lfsr_adv;
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
      if (w_state_next == ST_RUN) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_pat_cur;
        end else if (w_accept) begin
          r_out_data  <= w_pat_next;
        end
      end else begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign done      = (r_state == ST_FINISH);

endmodule
